// File: rtl/radar_roi_collector.sv
// radar_roi_collector: issues a region-of-interest request to the radar pixel
// engine, then reduces the returned pixel burst to a count, a sum and (optionally)
// a maximum. It flags length mismatches, mid-burst restarts and start timeouts.
// Optional feature macro: ROI_MAX_EN builds the max comparator. Without it,
// pix_max is tied to 0.
module radar_roi_collector #(
    parameter int ROW_W   = 8,
    parameter int COL_W   = 8,
    parameter int CH_W    = 4,
    parameter int PIX_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ROW_W-1:0]             req_row1,
    input  logic [ROW_W-1:0]             req_row2,
    input  logic [COL_W-1:0]             req_col1,
    input  logic [COL_W-1:0]             req_col2,
    input  logic [CH_W-1:0]              req_ch,
    output logic [ROW_W-1:0]             row_idx1,
    output logic [ROW_W-1:0]             row_idx2,
    output logic [COL_W-1:0]             col_idx1,
    output logic [COL_W-1:0]             col_idx2,
    output logic [CH_W-1:0]              channel_num,
    output logic                         roi_req,
    input  logic                         data_start,
    input  logic                         data_end,
    input  logic [PIX_W-1:0]             pixel_out,
    output logic                         result_valid,
    output logic [ROW_W+COL_W:0]         pix_count,
    output logic [PIX_W+ROW_W+COL_W+1:0] pix_sum,
    output logic [PIX_W-1:0]             pix_max,
    output logic                         err_len,
    output logic                         err_timeout
);

    localparam int CNT_W = ROW_W + COL_W + 1;
    localparam int SUM_W = PIX_W + ROW_W + COL_W + 2;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] exp_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic             accept;
    logic             pix_acc;
    logic             first_pix;
    logic             restart;
    logic             timed_out;
    logic [ROW_W-1:0] row_lo, row_hi;
    logic [COL_W-1:0] col_lo, col_hi;
    logic [ROW_W:0]   rows;
    logic [COL_W:0]   cols;

    assign accept    = req_valid && req_ready;
    // In WAIT only a data_start pixel counts; in STREAM every cycle carries a pixel.
    assign pix_acc   = ((state == S_WAIT) && data_start) || (state == S_STREAM);
    // The first pixel of a burst, or a restart, reloads the accumulators.
    assign first_pix = (state == S_WAIT) || data_start;
    assign restart   = (state == S_STREAM) && data_start;
    assign timed_out = (state == S_WAIT) && !data_start && (to_cnt == TO_W'(TIMEOUT - 1));
    assign cnt_nxt   = first_pix ? CNT_W'(1) : pix_count + CNT_W'(1);

    // Corner normalisation and expected pixel count, at full width so nothing wraps.
    assign row_lo = (req_row1 < req_row2) ? req_row1 : req_row2;
    assign row_hi = (req_row1 < req_row2) ? req_row2 : req_row1;
    assign col_lo = (req_col1 < req_col2) ? req_col1 : req_col2;
    assign col_hi = (req_col1 < req_col2) ? req_col2 : req_col1;
    assign rows   = (ROW_W + 1)'(row_hi - row_lo) + (ROW_W + 1)'(1);
    assign cols   = (COL_W + 1)'(col_hi - col_lo) + (COL_W + 1)'(1);

    // Next-state logic for the request/collect sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_WAIT;
            S_WAIT:   begin
                if (data_start)     state_nxt = data_end ? S_DONE : S_STREAM;
                else if (timed_out) state_nxt = S_DONE;
            end
            S_STREAM: if (data_end) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register and the registered handshake/strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            req_ready    <= 1'b0;
            roi_req      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            req_ready    <= (state_nxt == S_IDLE);
            roi_req      <= (state_nxt == S_ISSUE);
            result_valid <= (state_nxt == S_DONE);
        end
    end

    // Capture the normalised command; it is held until the next accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx1    <= '0;
            row_idx2    <= '0;
            col_idx1    <= '0;
            col_idx2    <= '0;
            channel_num <= '0;
            exp_cnt     <= '0;
        end else if (accept) begin
            row_idx1    <= row_lo;
            row_idx2    <= row_hi;
            col_idx1    <= col_lo;
            col_idx2    <= col_hi;
            channel_num <= req_ch;
            exp_cnt     <= CNT_W'(rows) * CNT_W'(cols);
        end
    end

    // Count/sum accumulation and the idle-cycle timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_count <= '0;
            pix_sum   <= '0;
            to_cnt    <= '0;
        end else if (state == S_ISSUE) begin
            pix_count <= '0;
            pix_sum   <= '0;
            to_cnt    <= '0;
        end else if (state == S_WAIT || state == S_STREAM) begin
            if (pix_acc) begin
                pix_count <= cnt_nxt;
                pix_sum   <= first_pix ? SUM_W'(pixel_out) : pix_sum + SUM_W'(pixel_out);
                to_cnt    <= '0;
            end else begin
                to_cnt    <= to_cnt + TO_W'(1);
            end
        end
    end

    // Error flags: restart is sticky, a length check runs on the last pixel,
    // and a timeout never raises the length error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else if (state == S_ISSUE) begin
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (restart || (pix_acc && data_end && (cnt_nxt != exp_cnt)))
                err_len <= 1'b1;
            if (timed_out)
                err_timeout <= 1'b1;
        end
    end

`ifdef ROI_MAX_EN
    // Running maximum, reloaded on the first pixel of a burst or on a restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix_max <= '0;
        else if (state == S_ISSUE)
            pix_max <= '0;
        else if (pix_acc)
            pix_max <= (first_pix || (pixel_out > pix_max)) ? pixel_out : pix_max;
    end
`else
    assign pix_max = '0;
`endif

endmodule
